rom_scan_ctrl: RTL and testbench

Sequencer that owns the read port of the 16x8 ROM used in the Exp1 labs. On a start request it walks a programmable address window (wrap-around allowed) and drives address and read-enable. It streams each word to a downstream consumer over a valid/ready handshake and keeps running sum, maximum and word count. Sits between the top-level control (buttons/FSM) and the ROM, and feeds the display/LED datapath.

---
 rtl/rom_scan_pkg.sv | 8 +
 rtl/rom_scan_acc.sv | 30 +++
 rtl/rom_scan_ctrl.sv | 83 ++++++++
 tb/tb_rom_scan_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rom_scan_pkg.sv
// rom_scan_pkg: shared sizes and FSM state encoding for the ROM scan sequencer
package rom_scan_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int SUM_W_DEF  = DATA_W_DEF + ADDR_W_DEF;
    localparam int ROM_DEPTH  = 1 << ADDR_W_DEF;
    typedef enum logic [1:0] {IDLE, READ, HOLD, FIN} state_t;
endpackage

// File: rtl/rom_scan_acc.sv
// rom_scan_acc: running sum, maximum and delivered-word count for one scan
module rom_scan_acc #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              upd,
    input  logic              inc,
    input  logic [DATA_W-1:0] data,
    output logic [SUM_W-1:0]  sum,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W:0]   cnt
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum     <= '0;
            max_val <= '0;
            cnt     <= '0;
        end else begin
            if (upd) begin
                sum     <= sum + SUM_W'(data);
                max_val <= data > max_val ? data : max_val;
            end
            if (inc) cnt <= cnt + (ADDR_W+1)'(1);
        end
    end
endmodule

// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl: walks a wrapping ROM address window and streams words over valid/ready
module rom_scan_ctrl
    import rom_scan_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W:0]   cnt
);
    state_t state;
    logic [ADDR_W-1:0] last_q;
    logic clr, upd, inc;

    assign clr = state == IDLE && start;
    assign upd = state == READ;
    assign inc = state == HOLD && out_ready;

    rom_scan_acc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SUM_W(SUM_W)) u_acc (
        .clk(clk), .rst(rst), .clr(clr), .upd(upd), .inc(inc),
        .data(rom_data), .sum(sum), .max_val(max_val), .cnt(cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_q    <= '0;
            rom_addr  <= '0;
            rom_rd_en <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    last_q    <= last_addr;
                    rom_addr  <= first_addr;
                    rom_rd_en <= 1'b1;
                    busy      <= 1'b1;
                    state     <= READ;
                end
                READ: begin
                    out_data  <= rom_data;
                    out_valid <= 1'b1;
                    rom_rd_en <= 1'b0;
                    state     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (rom_addr == last_q) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        rom_addr  <= rom_addr + ADDR_W'(1);
                        rom_rd_en <= 1'b1;
                        state     <= READ;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rom_scan_ctrl.sv
// tb_rom_scan_ctrl: directed scans against a 0x10+i ROM model with a word scoreboard
module tb_rom_scan_ctrl;
    import rom_scan_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  first_addr = '0;
    logic [3:0]  last_addr = '0;
    logic [3:0]  rom_addr;
    logic        rom_rd_en;
    logic [7:0]  rom_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [11:0] sum;
    logic [7:0]  max_val;
    logic [4:0]  cnt;
    logic [7:0]  sb[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_rd_en ? 8'h10 + 8'(rom_addr) : 8'h00;

    rom_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_data(rom_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .sum(sum), .max_val(max_val), .cnt(cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_addr"}, 32'(rom_addr), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_sum"}, 32'(sum), 0);
        chk({tag, "_max"}, 32'(max_val), 0);
        chk({tag, "_cnt"}, 32'(cnt), 0);
        chk({tag, "_ctl"}, {28'd0, out_valid, busy, done, rom_rd_en}, 0);
    endtask

    task automatic run_scan(input logic [3:0] f, input logic [3:0] l, input int stall_idx,
                            input int stall_n, input bit poke_start);
        logic [3:0]  span;
        logic [11:0] es;
        logic [7:0]  em, d;
        int len, word, dones, done_c;
        span = l - f;
        len = int'(span) + 1;
        es = '0;
        em = '0;
        for (int i = 0; i < len; i++) begin
            d = 8'h10 + 8'((int'(f) + i) % 16);
            sb.push_back(d);
            es += 12'(d);
            em = d > em ? d : em;
        end
        first_addr = f;
        last_addr = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rd_en_after_start", {30'd0, rom_rd_en, out_valid}, 32'b10);
        chk("acc_cleared", 32'(sum) | 32'(cnt), 0);
        word = 0;
        dones = 0;
        done_c = -1;
        for (int c = 0; c < 400 && dones == 0; c++) begin
            start = poke_start && c == 3;
            if (out_valid) begin
                if (word == stall_idx && stall_n > 0) begin
                    out_ready = 1'b0;
                    repeat (stall_n) begin
                        @(negedge clk);
                        chk("stall_data", 32'(out_data), 32'(sb[0]));
                        chk("stall_ctl", {30'd0, out_valid, rom_rd_en}, 32'b10);
                        chk("stall_addr", 32'(rom_addr), 32'(4'(int'(f) + word)));
                    end
                    out_ready = 1'b1;
                end
                if (sb.size() == 0) chk("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
                else chk("word", 32'(out_data), 32'(sb.pop_front()));
                word++;
            end
            if (done) begin
                dones++;
                done_c = c;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_cycle", 32'(done_c), 32'(2 * len));
        chk("done_after", {30'd0, done, busy}, 0);
        chk("words_left", 32'(sb.size()), 0);
        chk("sum", 32'(sum), 32'(es));
        chk("max", 32'(max_val), 32'(em));
        chk("cnt", 32'(cnt), 32'(len));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle_zero("reset");
        run_scan(4'd0, 4'd15, -1, 0, 1'b0);
        chk("full_sum_lit", 32'(sum), 32'h178);
        run_scan(4'd3, 4'd3, -1, 0, 1'b0);
        chk("single_sum_lit", 32'(sum), 32'h013);
        run_scan(4'd14, 4'd1, -1, 0, 1'b0);
        chk("wrap_sum_lit", 32'(sum), 32'h05E);
        run_scan(4'd0, 4'd15, 1, 5, 1'b0);
        chk("stall_sum_lit", 32'(sum), 32'h178);
        run_scan(4'd0, 4'd15, -1, 0, 1'b1);
        repeat (3) @(negedge clk);
        chk("results_kept", 32'(sum), 32'h178);
        chk("results_kept_cnt", 32'(cnt), 32'd16);
        run_scan(4'd0, 4'd1, -1, 0, 1'b0);
        chk("b2b_sum_lit", 32'(sum), 32'h021);
        sb.delete();
        first_addr = 4'd0;
        last_addr = 4'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && !(out_valid && out_data == 8'h14); c++) @(negedge clk);
        chk("reach_word5", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h14});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero("midscan_rst");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", {30'd0, done, busy}, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
